truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner.sv | 118 +++++++++++
 tb/tb_truth_table_scanner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Exhaustive 4-input function tester: walks vectors 0..15, samples s_in after a
// settle window, and compares the captured truth table against a latched golden table.
module truth_table_scanner #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        s_in,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        err_valid,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [3:0]  r_vec;
  logic [15:0] r_exp;
  logic [15:0] r_tt;
  logic [4:0]  r_err_cnt;
  logic [3:0]  r_first;
  logic        r_err_valid;
  logic        r_pass;
  logic        r_busy;
  logic        r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= 4'd0;
      r_cnt       <= 4'd0;
      r_vec       <= 4'd0;
      r_exp       <= 16'd0;
      r_tt        <= 16'd0;
      r_err_cnt   <= 5'd0;
      r_first     <= 4'd0;
      r_err_valid <= 1'b0;
      r_pass      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_exp       <= expected;
            r_idx       <= 4'd0;
            r_tt        <= 16'd0;
            r_err_cnt   <= 5'd0;
            r_first     <= 4'd0;
            r_err_valid <= 1'b0;
            r_pass      <= 1'b0;
            r_cnt       <= SETTLE_L;
            r_vec       <= 4'd0;
            r_busy      <= 1'b1;
            r_state     <= DRIVE;
          end
        end
        DRIVE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_tt[r_idx] <= s_in;
          if (s_in != r_exp[r_idx]) begin
            r_err_cnt <= r_err_cnt + 5'd1;
            if (!r_err_valid) begin
              r_first     <= r_idx;
              r_err_valid <= 1'b1;
            end
          end
          // Index 15 is terminal; idx never wraps inside a run.
          if (r_idx == 4'd15) begin
            r_vec   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_vec   <= r_idx + 4'd1;
            r_cnt   <= SETTLE_L;
            r_state <= DRIVE;
          end
        end
        FIN: begin
          // err_count already includes the last vector, updated on the entry edge.
          r_pass  <= (r_err_cnt == 5'd0);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign {x, y, w, z} = r_vec;
  assign busy         = r_busy;
  assign done         = r_done;
  assign tt           = r_tt;
  assign err_count    = r_err_cnt;
  assign first_err    = r_first;
  assign err_valid    = r_err_valid;
  assign pass         = r_pass;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3)
// driven by table-defined functions, checked against a mismatch-mask reference model.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start_v = 2'b00;
  logic [15:0] expected = 16'd0;
  logic [15:0] fn_tbl [2];

  wire  [1:0]  s_in_v;
  wire  [3:0]  vec_v [2];
  wire  [1:0]  busy_v, done_v, errv_v, pass_v;
  wire  [15:0] tt_v [2];
  wire  [4:0]  ec_v [2];
  wire  [3:0]  fe_v [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wire gx, gy, gw, gz;
    truth_table_scanner #(.SETTLE(g == 0 ? 1 : 3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .expected(expected),
      .s_in(s_in_v[g]), .x(gx), .y(gy), .w(gw), .z(gz),
      .busy(busy_v[g]), .done(done_v[g]), .tt(tt_v[g]), .err_count(ec_v[g]),
      .first_err(fe_v[g]), .err_valid(errv_v[g]), .pass(pass_v[g])
    );
    assign vec_v[g]  = {gx, gy, gw, gz};
    assign s_in_v[g] = fn_tbl[g][vec_v[g]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic chk_idle_zero(input int d, input string tag);
    chk({tag, "_busy"}, busy_v[d], 0);
    chk({tag, "_done"}, done_v[d], 0);
    chk({tag, "_vec"},  vec_v[d], 0);
    chk({tag, "_tt"},   tt_v[d], 0);
    chk({tag, "_ec"},   ec_v[d], 0);
    chk({tag, "_fe"},   fe_v[d], 0);
    chk({tag, "_errv"}, errv_v[d], 0);
    chk({tag, "_pass"}, pass_v[d], 0);
  endtask

  // Reference: results follow from the mismatch mask between function and golden table.
  task automatic chk_results(input int d, input logic [15:0] fn, input logic [15:0] ev, input string tag);
    logic [15:0] mism;
    int fe;
    mism = fn ^ ev;
    fe = 0;
    for (int i = 15; i >= 0; i--) if (mism[i]) fe = i;
    chk({tag, "_tt"},   tt_v[d], fn);
    chk({tag, "_ec"},   ec_v[d], $countones(mism));
    chk({tag, "_fe"},   fe_v[d], fe);
    chk({tag, "_errv"}, errv_v[d], mism != 0);
    chk({tag, "_pass"}, pass_v[d], mism == 0);
  endtask

  // Starts a run and follows it cycle by cycle; returns one cycle after done (IDLE).
  task automatic run_scan(input int d, input logic [15:0] fn, input logic [15:0] ev,
                          input bit disturb, input bit poke_done, input string tag);
    int s, per, c, done_at, seqerr;
    s = (d == 0) ? 1 : 3;
    per = s + 1;
    fn_tbl[d] = fn;
    expected = ev;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    c = 0; done_at = -1; seqerr = 0;
    while (c < 16 * per + 4 && done_at < 0) begin
      if (c < 16 * per) begin
        if (!busy_v[d] || done_v[d] || vec_v[d] != 4'(c / per)) seqerr++;
      end
      if (done_v[d]) begin
        done_at = c;
        if (busy_v[d] || vec_v[d] != 0) seqerr++;
        if (poke_done) start_v[d] = 1'b1;
      end
      if (disturb && c == 4 * per) begin
        start_v[d] = 1'b1;
        expected = ~ev;
      end
      if (disturb && c == 4 * per + 1) start_v[d] = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    start_v[d] = 1'b0;
    expected = ev;
    chk({tag, "_done_at"}, done_at, 16 * per);
    chk({tag, "_seq"}, seqerr, 0);
    chk({tag, "_idle_vec"}, vec_v[d], 0);
    chk_results(d, fn, ev, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dd, cc, dseen;
    logic [15:0] f, e;
    fn_tbl[0] = 16'd0;
    fn_tbl[1] = 16'd0;
    #2;
    chk_idle_zero(0, "rst0");
    chk_idle_zero(1, "rst1");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_scan(0, 16'h8C6B, 16'h8C6B, 0, 0, "golden");
    run_scan(0, 16'h0000, 16'h8C6B, 0, 0, "sa0");
    // Second run begins the cycle after done; first run results were checked just above.
    run_scan(1, 16'hFFFF, 16'h8C6B, 0, 0, "sa1_s3");
    chk("sa1_fe_direct", fe_v[1], 2);
    run_scan(1, 16'h8C6B, 16'h8C6B, 0, 0, "b2b_s3");

    // Start pulsed and expected changed mid-run: no effect.
    run_scan(0, 16'h1234, 16'h1230, 1, 0, "disturb");
    // Start during the done cycle is ignored.
    run_scan(1, 16'hA5A5, 16'h5A5A, 0, 1, "poke");
    repeat (3) @(posedge clk);
    #1;
    chk("poke_idle_busy", busy_v[1], 0);
    chk_results(1, 16'hA5A5, 16'h5A5A, "poke_hold");

    // Abort after vector 7 is captured.
    fn_tbl[0] = 16'hFFFF;
    expected = 16'h0000;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("abort_pre_vec", vec_v[0], 8);
    chk("abort_pre_ec", ec_v[0], 8);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_zero(0, "abort");
    dseen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) dseen++;
    end
    chk("abort_no_done", dseen, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_scan(0, 16'h0F0F, 16'h0F0E, 0, 0, "post_rst");

    for (int k = 0; k < 6; k++) begin
      dd = int'($urandom_range(0, 1));
      f = 16'($urandom);
      cc = int'($urandom_range(0, 2));
      e = (cc == 0) ? f : (cc == 1) ? ~f : 16'($urandom);
      run_scan(dd, f, e, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
